// File: rtl/op_sched_pkg.sv
// ============================================================================
// op_sched_pkg : shared widths, types and FSM encoding for op_schedule_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package op_sched_pkg;

    localparam int CTRL_W   = 16;
    localparam int NUM_DIMS = 3;

    typedef logic [CTRL_W-1:0] ctrl_var_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } op_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_loop_counter.sv
// ============================================================================
// ctrl_loop_counter : one loop dimension, counts 0..EXTENT-1 on inc
// Rev 1.0
// ============================================================================
`default_nettype none

module ctrl_loop_counter
    import op_sched_pkg::*;
#(
    parameter int EXTENT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [CTRL_W-1:0] value,
    output logic              wrap
);

    localparam ctrl_var_t c_last = ctrl_var_t'(EXTENT - 1);

    ctrl_var_t r_value;

    // wrap flags "at last value", so the next inc rolls over and carries outward
    assign wrap  = (r_value == c_last);
    assign value = r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= wrap ? '0 : r_value + ctrl_var_t'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/op_schedule_ctrl.sv
// ============================================================================
// op_schedule_ctrl : affine loop-nest scheduler driving one buffer op port
// Optional feature macro: OP_SCHED_CTRL_STALL_EN (adds the stall input). Rev 1.0
// ============================================================================
`default_nettype none

module op_schedule_ctrl
    import op_sched_pkg::*;
#(
    parameter int EXTENT0     = 1,
    parameter int EXTENT1     = 64,
    parameter int EXTENT2     = 64,
    parameter int START_DELAY = 0,
    parameter int II          = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
`ifdef OP_SCHED_CTRL_STALL_EN
    input  logic              stall,
`endif
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl_vars [NUM_DIMS-1:0],
    output logic              done
);

    localparam ctrl_var_t  c_delay_last = ctrl_var_t'((START_DELAY == 0) ? 0 : START_DELAY - 1);
    localparam logic [7:0] c_ii_last    = 8'(II - 1);
    localparam int         c_extent [NUM_DIMS] = '{EXTENT0, EXTENT1, EXTENT2};

    op_sched_state_t r_state, w_state_nxt;
    ctrl_var_t       r_delay_cnt, w_delay_nxt;
    logic [7:0]      r_ii_cnt, w_ii_nxt;
    logic            r_fire, w_fire_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_done;
    logic            w_clr, w_inc, w_stall, w_all_last;
    logic [NUM_DIMS-1:0] w_wrap, w_carry;

`ifdef OP_SCHED_CTRL_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // innermost dim steps on every issue; outer dims step on the inner wraps
    assign w_carry[2]  = w_inc;
    assign w_carry[1]  = w_inc & w_wrap[2];
    assign w_carry[0]  = w_inc & w_wrap[2] & w_wrap[1];
    assign w_all_last  = &w_wrap;

    for (genvar d = 0; d < NUM_DIMS; d++) begin : g_dim
        ctrl_loop_counter #(
            .EXTENT (c_extent[d])
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (w_clr),
            .inc   (w_carry[d]),
            .value (ctrl_vars[d]),
            .wrap  (w_wrap[d])
        );
    end

    // r_fire marks an issue slot and survives a stall; r_valid is the masked copy
    always_comb begin
        w_state_nxt = r_state;
        w_delay_nxt = r_delay_cnt;
        w_ii_nxt    = r_ii_cnt;
        w_fire_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        if (flush) begin
            w_clr       = 1'b1;
            w_delay_nxt = '0;
            w_ii_nxt    = '0;
            if (START_DELAY == 0) begin
                w_state_nxt = ST_RUN;
                w_fire_nxt  = 1'b1;
            end else begin
                w_state_nxt = ST_DELAY;
            end
            w_valid_nxt = w_fire_nxt;
        end else if (w_stall) begin
            w_fire_nxt = r_fire;
        end else begin
            case (r_state)
                ST_DELAY: begin
                    if (r_delay_cnt == c_delay_last) begin
                        w_state_nxt = ST_RUN;
                        w_fire_nxt  = 1'b1;
                        w_ii_nxt    = '0;
                    end else begin
                        w_delay_nxt = r_delay_cnt + ctrl_var_t'(1);
                    end
                end
                ST_RUN: begin
                    if (r_fire && w_all_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_ii_nxt = (r_ii_cnt == c_ii_last) ? 8'd0 : r_ii_cnt + 8'd1;
                        if (w_ii_nxt == 8'd0) begin
                            w_fire_nxt = 1'b1;
                            w_inc      = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            w_valid_nxt = w_fire_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_delay_cnt <= '0;
            r_ii_cnt    <= '0;
            r_fire      <= 1'b0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_delay_cnt <= w_delay_nxt;
            r_ii_cnt    <= w_ii_nxt;
            r_fire      <= w_fire_nxt;
            r_valid     <= w_valid_nxt;
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    assign valid = r_valid;
    assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_op_schedule_ctrl.sv
// ============================================================================
// tb_op_schedule_ctrl : three parameterisations against a step-count model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_op_schedule_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    logic        va, vb, vc, da, db, dc;
    logic [15:0] cva [2:0];
    logic [15:0] cvb [2:0];
    logic [15:0] cvc [2:0];

    op_schedule_ctrl #(.EXTENT0(2), .EXTENT1(2), .EXTENT2(3), .START_DELAY(5), .II(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
`ifdef OP_SCHED_CTRL_STALL_EN
        .stall(stall),
`endif
        .valid(va), .ctrl_vars(cva), .done(da));

    op_schedule_ctrl #(.EXTENT0(1), .EXTENT1(1), .EXTENT2(1), .START_DELAY(0), .II(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
`ifdef OP_SCHED_CTRL_STALL_EN
        .stall(stall),
`endif
        .valid(vb), .ctrl_vars(cvb), .done(db));

    op_schedule_ctrl u_dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush),
`ifdef OP_SCHED_CTRL_STALL_EN
        .stall(stall),
`endif
        .valid(vc), .ctrl_vars(cvc), .done(dc));

    // schedule parameters of the three instances, and model state per instance
    int p_e0 [3] = '{2, 1, 1};
    int p_e1 [3] = '{2, 1, 64};
    int p_e2 [3] = '{3, 1, 64};
    int p_d  [3] = '{5, 0, 0};
    int p_ii [3] = '{3, 1, 1};

    bit act [3];
    int s   [3];
    bit ent [3];

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [49:0] observe(input int i);
        case (i)
            0:       return {va, da, cva[0], cva[1], cva[2]};
            1:       return {vb, db, cvb[0], cvb[1], cvb[2]};
            default: return {vc, dc, cvc[0], cvc[1], cvc[2]};
        endcase
    endfunction

    // s = number of non-stalled edges since the last flush; iteration k is due at s = D + k*II
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                act[i] = 1'b0;
            end else if (flush) begin
                act[i] = 1'b1;
                s[i]   = 0;
                ent[i] = 1'b1;
            end else if (act[i]) begin
                if (stall) ent[i] = 1'b0;
                else begin
                    s[i]++;
                    ent[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int n, last, k;
            logic ev, ed;
            logic [47:0] evars;
            logic [49:0] o;
            n    = p_e0[i] * p_e1[i] * p_e2[i];
            last = p_d[i] + (n - 1) * p_ii[i];
            ev   = 1'b0;
            ed   = 1'b0;
            k    = 0;
            if (act[i]) begin
                ed = (s[i] > last);
                ev = ent[i] && (s[i] >= p_d[i]) && (s[i] <= last) && (((s[i] - p_d[i]) % p_ii[i]) == 0);
                if (s[i] >= p_d[i]) begin
                    k = (s[i] - p_d[i]) / p_ii[i];
                    if (k > n - 1) k = n - 1;
                end
            end
            evars = {16'(k / (p_e1[i] * p_e2[i])), 16'((k / p_e2[i]) % p_e1[i]), 16'(k % p_e2[i])};
            o = observe(i);
            chk($sformatf("valid[%0d]", i), 64'(o[49]), 64'(ev));
            chk($sformatf("done[%0d]", i), 64'(o[48]), 64'(ed));
            chk($sformatf("ctrl_vars[%0d]", i), 64'(o[47:0]), 64'(evars));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_stall(input int one_in);
`ifdef OP_SCHED_CTRL_STALL_EN
        stall = ($urandom_range(0, one_in - 1) == 0);
`else
        stall = 1'b0;
`endif
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0;
            s[i]   = 0;
            ent[i] = 1'b0;
        end

        // reset state, then idle with no flush
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) step();

        // full uninterrupted schedule for every instance
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            rand_stall(16);
            step();
        end

        // random flushes and stalls
        for (int c = 0; c < 800; c++) begin
            flush = ($urandom_range(0, 49) == 0);
            rand_stall(8);
            step();
        end
        flush = 1'b0;
        stall = 1'b0;

        // restart mid-run
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 0; c < 20; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 0; c < 60; c++) step();

        // asynchronous reset between edges clears outputs at once
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) act[i] = 1'b0;
        check_all();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
